// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit.
// Multiplies use 32-cycle shift-add. Divides use 32-cycle restoring division.
// Each result is produced as one register-file write-back beat.
module mdu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  rd_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  wa_o,
    output logic        we_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 6;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic                r_neg;
    logic                r_dz;
    logic [2*XLEN-1:0]   r_x;     // multiplicand (shifts left) / dividend-quotient in [31:0]
    logic [XLEN-1:0]     r_b;     // multiplier (shifts right) / divisor
    logic [2*XLEN-1:0]   r_acc;   // product accumulator
    logic [XLEN-1:0]     r_rem;   // partial remainder
    logic                r_busy;
    logic                r_valid;
    logic                r_we;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_wa;

    logic                w_a_sgn_op;
    logic                w_b_sgn_op;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_neg_flag;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [XLEN:0]       w_sh;
    logic [XLEN:0]       w_diff;
    logic                w_ge;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    // Operand signedness per funct3; MUL low word is computed as signed.
    always_comb begin
        w_a_sgn_op = 1'b0;
        w_b_sgn_op = 1'b0;
        case (op_i)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                w_a_sgn_op = 1'b1;
                w_b_sgn_op = 1'b1;
            end
            OP_MULHSU: w_a_sgn_op = 1'b1;
            default: ;
        endcase
    end

    // Magnitudes and result sign captured at accept.
    always_comb begin
        w_a_neg    = w_a_sgn_op & a_i[XLEN-1];
        w_b_neg    = w_b_sgn_op & b_i[XLEN-1];
        w_a_mag    = w_a_neg ? (~a_i + XLEN'(1)) : a_i;
        w_b_mag    = w_b_neg ? (~b_i + XLEN'(1)) : b_i;
        w_neg_flag = (op_i[2] & op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        w_acc_next = r_acc + (r_b[0] ? r_x : (2*XLEN)'(0));
        w_sh       = {r_rem, r_x[XLEN-1]};
        w_diff     = w_sh - {1'b0, r_b};
        w_ge       = ~w_diff[XLEN];
    end

    // Sign fix-up and result selection.
    always_comb begin
        w_prod = r_neg ? (~r_acc + (2*XLEN)'(1)) : r_acc;
        w_quo  = r_dz ? {XLEN{1'b1}} : (r_neg ? (~r_x[XLEN-1:0] + XLEN'(1)) : r_x[XLEN-1:0]);
        w_rem  = r_neg ? (~r_rem + XLEN'(1)) : r_rem;
        w_fix_res = w_prod[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:           w_fix_res = w_prod[XLEN-1:0];
            OP_DIV, OP_DIVU:  w_fix_res = w_quo;
            OP_REM, 3'b111:   w_fix_res = w_rem;
            default:          w_fix_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_x      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
            r_result <= '0;
            r_wa     <= '0;
        end else begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i && !kill_i) begin
                        r_op    <= op_i;
                        r_rd    <= rd_i;
                        r_neg   <= w_neg_flag;
                        r_dz    <= (b_i == '0);
                        r_x     <= {XLEN'(0), w_a_mag};
                        r_b     <= w_b_mag;
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_op[2]) begin
                            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
                            r_x   <= {r_x[2*XLEN-1:XLEN], r_x[XLEN-2:0], w_ge};
                        end else begin
                            r_acc <= w_acc_next;
                            r_x   <= {r_x[2*XLEN-2:0], 1'b0};
                            r_b   <= {1'b0, r_b[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN - 1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (kill_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_wa     <= r_rd;
                        r_valid  <= 1'b1;
                        r_we     <= (r_rd != '0);
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign wa_o     = r_wa;
    assign we_o     = r_we;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for the RV32M multiply/divide unit.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  wa;
    logic        we;

    int n_checks;
    int n_errors;

    mdu dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .rd_i     (rd),
        .kill_i   (kill),
        .busy_o   (busy),
        .valid_o  (valid),
        .result_o (result),
        .wa_o     (wa),
        .we_o     (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M semantics with 64-bit products and native int division.
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        int ix, iy;
        logic [31:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'd0, x};
        zy = {32'd0, y};
        ix = x;
        iy = y;
        r  = '0;
        case (f)
            3'd0: begin p = sx * sy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * zy; r = p[63:32]; end
            3'd3: begin p = zx * zy; r = p[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = 32'(ix / iy);
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(ix % iy);
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Drive one request, wait (bounded) for the strobe and sample the beat after it.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] d, output int lat, output logic [31:0] res,
                          output logic [4:0] wa_v, output logic we_v,
                          output logic busy_end, output logic valid_end);
        @(negedge clk);
        req = 1'b1; op = f; a = x; b = y; rd = d;
        @(posedge clk); #1;
        req = 1'b0;
        op = 3'($urandom()); a = $urandom(); b = $urandom(); rd = 5'($urandom());
        lat = 0;
        while (valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = result;
        wa_v = wa;
        we_v = we;
        @(posedge clk); #1;
        busy_end  = busy;
        valid_end = valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || we !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy=%b valid=%b we=%b expected 000", busy, valid, we);
        end
        n_checks++;
        if (result !== 32'd0 || wa !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_data: result=%h wa=%0d expected 0/0", result, wa);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  vo[12];
        logic [31:0] va[12];
        logic [31:0] vb[12];
        logic [31:0] ve[12];
        int lat;
        logic [31:0] res;
        logic [4:0] wa_v, d;
        logic we_v, be, ve_end;
        vo = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        va = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        vb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
               32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ve = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
               32'h7FFF_FFFC, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 12; i++) begin
            d = 5'(i + 5);
            run_op(vo[i], va[i], vb[i], d, lat, res, wa_v, we_v, be, ve_end);
            n_checks++;
            if (res !== ve[i]) begin
                n_errors++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i, res, ve[i]);
            end
            n_checks++;
            if (lat !== 33) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 33", i, lat);
            end
            n_checks++;
            if (wa_v !== d || we_v !== 1'b1) begin
                n_errors++;
                $display("FAIL directed_wb[%0d]: wa=%0d we=%b expected %0d/1", i, wa_v, we_v, d);
            end
            n_checks++;
            if (be !== 1'b0 || ve_end !== 1'b0) begin
                n_errors++;
                $display("FAIL directed_after[%0d]: busy=%b valid=%b expected 0/0", i, be, ve_end);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] res, x, y, exp;
        logic [4:0] wa_v, d;
        logic [2:0] f;
        logic we_v, be, ve_end;
        logic [31:0] spec[4];
        spec = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom());
            x = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 3)] : $urandom();
            y = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 3)] : $urandom();
            d = 5'($urandom());
            exp = ref_mdu(f, x, y);
            run_op(f, x, y, d, lat, res, wa_v, we_v, be, ve_end);
            n_checks++;
            if (res !== exp || lat !== 33) begin
                n_errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d expected %h lat 33",
                         i, f, x, y, res, lat, exp);
            end
            n_checks++;
            if (wa_v !== d || we_v !== (d != 5'd0)) begin
                n_errors++;
                $display("FAIL random_wb[%0d]: wa=%0d we=%b expected %0d/%b", i, wa_v, we_v, d, d != 5'd0);
            end
        end
    endtask

    task automatic test_rd0();
        int lat;
        logic [31:0] res;
        logic [4:0] wa_v;
        logic we_v, be, ve_end;
        run_op(3'd0, 32'd6, 32'd7, 5'd0, lat, res, wa_v, we_v, be, ve_end);
        n_checks++;
        if (lat !== 33 || we_v !== 1'b0 || res !== 32'd42) begin
            n_errors++;
            $display("FAIL rd0: lat=%0d we=%b result=%h expected 33/0/0000002a", lat, we_v, res);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] e1, e2;
        e1 = ref_mdu(3'd5, 32'd1000, 32'd7);
        e2 = ref_mdu(3'd0, 32'd1234, 32'd99);
        @(negedge clk);
        req = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7; rd = 5'd3;
        @(posedge clk); #1;
        op = 3'd0; a = 32'd1234; b = 32'd99; rd = 5'd4;
        lat = 0;
        while (valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 33 || result !== e1 || wa !== 5'd3) begin
            n_errors++;
            $display("FAIL b2b_first: lat=%0d result=%h wa=%0d expected 33/%h/3", lat, result, wa, e1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle_gap: busy=%b expected 0", busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second_accept: busy=%b expected 1", busy);
        end
        req = 1'b0;
        lat = 0;
        while (valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 33 || result !== e2 || wa !== 5'd4) begin
            n_errors++;
            $display("FAIL b2b_second: lat=%0d result=%h wa=%0d expected 33/%h/4", lat, result, wa, e2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_req_kill();
        logic saw;
        @(negedge clk);
        req = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; rd = 5'd1;
        @(posedge clk); #1;
        req = 1'b0; kill = 1'b0;
        saw = busy;
        repeat (40) begin
            @(posedge clk); #1;
            saw = saw | busy | valid;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++;
            $display("FAIL req_kill_idle: activity=%b expected 0", saw);
        end
    endtask

    task automatic test_kill();
        logic [31:0] prev;
        logic saw;
        prev = result;
        @(negedge clk);
        req = 1'b1; op = 3'd0; a = 32'd11; b = 32'd13; rd = 5'd9;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_errors++;
            $display("FAIL kill_busy: busy=%b valid=%b expected 0/0", busy, valid);
        end
        @(negedge clk);
        kill = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw = saw | valid;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++;
            $display("FAIL kill_no_valid: valid seen=%b expected 0", saw);
        end
        n_checks++;
        if (result !== prev) begin
            n_errors++;
            $display("FAIL kill_result_hold: got %h expected %h", result, prev);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        logic [31:0] res;
        logic [4:0] wa_v;
        logic we_v, be, ve_end;
        run_op(3'd0, 32'd3, 32'd5, 5'd7, lat, res, wa_v, we_v, be, ve_end);
        @(negedge clk);
        req = 1'b1; op = 3'd4; a = 32'd100; b = 32'd9; rd = 5'd8;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || we !== 1'b0 || result !== 32'd0 || wa !== 5'd0) begin
            n_errors++;
            $display("FAIL rst_mid: busy=%b valid=%b we=%b result=%h wa=%0d expected all 0",
                     busy, valid, we, result, wa);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd2, lat, res, wa_v, we_v, be, ve_end);
        n_checks++;
        if (lat !== 33 || res !== 32'hFFFF_FFFE || wa_v !== 5'd2) begin
            n_errors++;
            $display("FAIL rst_recover: lat=%0d result=%h wa=%0d expected 33/fffffffe/2", lat, res, wa_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        req  = 1'b0;
        kill = 1'b0;
        op   = '0;
        a    = '0;
        b    = '0;
        rd   = '0;
        test_reset();
        test_directed();
        test_random();
        test_rd0();
        test_back_to_back();
        test_req_kill();
        test_kill();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
